// File: rtl/mem_responder_if.sv
// CPU-side handshake bundle for mem_responder: fetch port 1 and data port 2.
// The shared port-2 data bus is a tri-state net and is wired as a separate inout.
interface mem_responder_if #(
  parameter int WORD_SIZE = 16
) ();
  logic                 read_m1;
  logic [WORD_SIZE-1:0] address1;
  logic [WORD_SIZE-1:0] data1;
  logic                 ready1;
  logic                 read_m2;
  logic                 write_m2;
  logic [WORD_SIZE-1:0] address2;
  logic                 ready2;
`ifdef MEM_STATS_EN
  logic [WORD_SIZE-1:0] rd_count;
  logic [WORD_SIZE-1:0] wr_count;
`endif

  modport master (
    output read_m1, address1, read_m2, write_m2, address2,
    input  data1, ready1, ready2
`ifdef MEM_STATS_EN
    , input rd_count, wr_count
`endif
  );

  modport slave (
    input  read_m1, address1, read_m2, write_m2, address2,
    output data1, ready1, ready2
`ifdef MEM_STATS_EN
    , output rd_count, wr_count
`endif
  );
endinterface

// File: rtl/mem_responder.sv
// Multi-cycle memory responder with independent IDLE/BUSY/RESP latency FSMs per port.
// Optional access counters (rd_count/wr_count) are enabled with `define MEM_STATS_EN.
module mem_responder #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_BITS = 8,
  parameter int LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  inout  wire  [WORD_SIZE-1:0] data2
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  logic [WORD_SIZE-1:0] mem_r [DEPTH];

  state_t               state1_r, next1_s;
  logic [3:0]           cnt1_r, cnt1_nxt_s;
  logic                 start1_s, resp1_s;
  logic [ADDR_BITS-1:0] addr1_r, rd1_idx_s;
  logic [WORD_SIZE-1:0] data1_r;
  logic                 ready1_r;

  state_t               state2_r, next2_s;
  logic [3:0]           cnt2_r, cnt2_nxt_s;
  logic                 start2_s, resp2_s, req2_s;
  logic [ADDR_BITS-1:0] addr2_r, idx2_s;
  logic [WORD_SIZE-1:0] wdata2_r, wdata2_s, data2_r;
  logic                 op_wr_r, wr_op_s, wr_commit_s;
  logic                 ready2_r, drive2_r;

  // Port-1 next-state and counter logic
  always_comb begin
    next1_s    = state1_r;
    cnt1_nxt_s = cnt1_r;
    start1_s   = 1'b0;
    resp1_s    = 1'b0;
    case (state1_r)
      IDLE: begin
        if (bus.read_m1) begin
          start1_s = 1'b1;
          if (SINGLE) begin
            next1_s    = RESP;
            resp1_s    = 1'b1;
            cnt1_nxt_s = 4'd0;
          end else begin
            next1_s    = BUSY;
            cnt1_nxt_s = CNT_LOAD;
          end
        end else begin
          next1_s = IDLE;
        end
      end
      BUSY: begin
        if (!bus.read_m1) begin
          next1_s    = IDLE;
          cnt1_nxt_s = 4'd0;
        end else if (cnt1_r == 4'd1) begin
          next1_s    = RESP;
          resp1_s    = 1'b1;
          cnt1_nxt_s = 4'd0;
        end else begin
          cnt1_nxt_s = cnt1_r - 4'd1;
        end
      end
      RESP:    next1_s = IDLE;
      default: next1_s = IDLE;
    endcase
  end

  // A single-cycle access reads through the live address; otherwise the latched one
  always_comb begin
    if (state1_r == IDLE) begin
      rd1_idx_s = bus.address1[ADDR_BITS-1:0];
    end else begin
      rd1_idx_s = addr1_r;
    end
  end

  // Port-1 state, address latch and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state1_r <= IDLE;
      cnt1_r   <= 4'd0;
      addr1_r  <= '0;
      data1_r  <= '0;
      ready1_r <= 1'b0;
    end else begin
      state1_r <= next1_s;
      cnt1_r   <= cnt1_nxt_s;
      ready1_r <= resp1_s;
      if (start1_s) addr1_r <= bus.address1[ADDR_BITS-1:0];
      if (resp1_s)  data1_r <= mem_r[rd1_idx_s];
    end
  end

  assign req2_s = bus.read_m2 | bus.write_m2;

  // Port-2 next-state and counter logic
  always_comb begin
    next2_s    = state2_r;
    cnt2_nxt_s = cnt2_r;
    start2_s   = 1'b0;
    resp2_s    = 1'b0;
    case (state2_r)
      IDLE: begin
        if (req2_s) begin
          start2_s = 1'b1;
          if (SINGLE) begin
            next2_s    = RESP;
            resp2_s    = 1'b1;
            cnt2_nxt_s = 4'd0;
          end else begin
            next2_s    = BUSY;
            cnt2_nxt_s = CNT_LOAD;
          end
        end else begin
          next2_s = IDLE;
        end
      end
      BUSY: begin
        if (!req2_s) begin
          next2_s    = IDLE;
          cnt2_nxt_s = 4'd0;
        end else if (cnt2_r == 4'd1) begin
          next2_s    = RESP;
          resp2_s    = 1'b1;
          cnt2_nxt_s = 4'd0;
        end else begin
          cnt2_nxt_s = cnt2_r - 4'd1;
        end
      end
      RESP:    next2_s = IDLE;
      default: next2_s = IDLE;
    endcase
  end

  // Port-2 operand select: live inputs from IDLE, latched ones from BUSY
  always_comb begin
    if (state2_r == IDLE) begin
      idx2_s   = bus.address2[ADDR_BITS-1:0];
      wr_op_s  = bus.write_m2;
      wdata2_s = data2;
    end else begin
      idx2_s   = addr2_r;
      wr_op_s  = op_wr_r;
      wdata2_s = wdata2_r;
    end
  end

  assign wr_commit_s = resp2_s & wr_op_s;

  // Port-2 state, operand latches and read response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state2_r <= IDLE;
      cnt2_r   <= 4'd0;
      addr2_r  <= '0;
      wdata2_r <= '0;
      op_wr_r  <= 1'b0;
      data2_r  <= '0;
      ready2_r <= 1'b0;
      drive2_r <= 1'b0;
    end else begin
      state2_r <= next2_s;
      cnt2_r   <= cnt2_nxt_s;
      ready2_r <= resp2_s;
      drive2_r <= resp2_s & ~wr_op_s;
      if (start2_s) begin
        addr2_r  <= bus.address2[ADDR_BITS-1:0];
        op_wr_r  <= bus.write_m2;
        wdata2_r <= data2;
      end
      if (resp2_s && !wr_op_s) data2_r <= mem_r[idx2_s];
    end
  end

  // Array write; port 1 reading the same edge still sees the old word
  always_ff @(posedge clk) begin
    if (!reset && wr_commit_s) mem_r[idx2_s] <= wdata2_s;
  end

  assign bus.data1  = data1_r;
  assign bus.ready1 = ready1_r;
  assign bus.ready2 = ready2_r;
  assign data2      = drive2_r ? data2_r : {WORD_SIZE{1'bz}};

`ifdef MEM_STATS_EN
  logic [WORD_SIZE-1:0] rd_count_r, wr_count_r;
  logic [1:0]           rd_inc_s;

  assign rd_inc_s = {1'b0, resp1_s} + {1'b0, resp2_s & ~wr_op_s};

  // Completed-access counters, wrapping naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count_r <= '0;
      wr_count_r <= '0;
    end else begin
      rd_count_r <= rd_count_r + WORD_SIZE'(rd_inc_s);
      wr_count_r <= wr_count_r + WORD_SIZE'(wr_commit_s);
    end
  end

  assign bus.rd_count = rd_count_r;
  assign bus.wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance for main traffic, LATENCY=3 for abort.
module tb_mem_responder;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_responder_if #(.WORD_SIZE(16)) ifa ();
  mem_responder_if #(.WORD_SIZE(16)) ifb ();
  wire  [15:0] data2_a, data2_b;
  logic        drv_a, drv_b;
  logic [15:0] wd_a, wd_b;

  assign data2_a = drv_a ? wd_a : 16'bz;
  assign data2_b = drv_b ? wd_b : 16'bz;

  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave), .data2(data2_a));
  mem_responder #(.WORD_SIZE(16), .ADDR_BITS(8), .LATENCY(3)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.slave), .data2(data2_b));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Port-2 write on instance A, checking the single ready2 pulse
  task automatic wr_a(input logic [15:0] addr, input logic [15:0] dat);
    ifa.write_m2 = 1'b1; ifa.address2 = addr; wd_a = dat;
    step(); chk("wr_busy_ready2", {15'd0, ifa.ready2}, 16'd0);
    step(); chk("wr_ready2", {15'd0, ifa.ready2}, 16'd1);
    ifa.write_m2 = 1'b0; wd_a = 16'hA5A5;
    step(); chk("wr_ready2_low", {15'd0, ifa.ready2}, 16'd0);
  endtask

  // Port-1 read on instance A with full LATENCY=2 timing
  task automatic rd1_a(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    ifa.read_m1 = 1'b1; ifa.address1 = addr;
    step(); chk({tag, "_busy"}, {15'd0, ifa.ready1}, 16'd0);
    step(); chk({tag, "_ready"}, {15'd0, ifa.ready1}, 16'd1);
    chk({tag, "_data"}, ifa.data1, exp);
    ifa.read_m1 = 1'b0;
    step(); chk({tag, "_ready_low"}, {15'd0, ifa.ready1}, 16'd0);
    chk({tag, "_hold"}, ifa.data1, exp);
  endtask

  initial begin
    reset = 1'b1;
    ifa.read_m1 = 1'b0; ifa.address1 = 16'd0; ifa.read_m2 = 1'b0; ifa.write_m2 = 1'b0; ifa.address2 = 16'd0;
    ifb.read_m1 = 1'b0; ifb.address1 = 16'd0; ifb.read_m2 = 1'b0; ifb.write_m2 = 1'b0; ifb.address2 = 16'd0;
    drv_a = 1'b1; wd_a = 16'hA5A5; drv_b = 1'b1; wd_b = 16'hA5A5;
    step(); step();
    reset = 1'b0;
    chk("rst_ready1", {15'd0, ifa.ready1}, 16'd0);
    chk("rst_ready2", {15'd0, ifa.ready2}, 16'd0);
    chk("rst_data1", ifa.data1, 16'd0);
    chk("rst_data2_z", data2_a, 16'hA5A5);
    step();

    // Basic fetch with LATENCY=2
    wr_a(16'h0005, 16'h1234);
    rd1_a("t1", 16'h0005, 16'h1234);

    // Port-2 write then read-back; bus released outside RESP
    wr_a(16'h0010, 16'hBEEF);
    chk("t2_idle_z", data2_a, 16'hA5A5);
    drv_a = 1'b0; ifa.read_m2 = 1'b1; ifa.address2 = 16'h0010;
    step(); chk("t2_busy_ready2", {15'd0, ifa.ready2}, 16'd0);
    step(); chk("t2_ready2", {15'd0, ifa.ready2}, 16'd1);
    chk("t2_data2", data2_a, 16'hBEEF);
    ifa.read_m2 = 1'b0;
    step(); chk("t2_ready2_low", {15'd0, ifa.ready2}, 16'd0);
    drv_a = 1'b1; #1;
    chk("t2_after_z", data2_a, 16'hA5A5);

    // Same-edge collision: port 1 sees the old word
    wr_a(16'h0020, 16'hAAAA);
    ifa.read_m1 = 1'b1; ifa.address1 = 16'h0020;
    ifa.write_m2 = 1'b1; ifa.address2 = 16'h0020; wd_a = 16'h5555;
    step(); step();
    chk("t3_ready1", {15'd0, ifa.ready1}, 16'd1);
    chk("t3_ready2", {15'd0, ifa.ready2}, 16'd1);
    chk("t3_old_data", ifa.data1, 16'hAAAA);
    ifa.read_m1 = 1'b0; ifa.write_m2 = 1'b0; wd_a = 16'hA5A5;
    step();
    rd1_a("t3_new", 16'h0020, 16'h5555);
`ifdef MEM_STATS_EN
    chk("stat_rd_a", ifa.rd_count, 16'd4);
    chk("stat_wr_a", ifa.wr_count, 16'd4);
`endif

    // LATENCY=3 instance: aborted write leaves memory and ready2 untouched
    ifb.write_m2 = 1'b1; ifb.address2 = 16'h0030; wd_b = 16'h1111;
    step(); step(); step();
    chk("t4_pre_ready2", {15'd0, ifb.ready2}, 16'd1);
    ifb.write_m2 = 1'b0; wd_b = 16'hA5A5;
    step();
    ifb.write_m2 = 1'b1; wd_b = 16'h2222;
    step();
    ifb.write_m2 = 1'b0; wd_b = 16'hA5A5;
    for (int i = 0; i < 3; i++) begin
      step(); chk("t4_abort_ready2", {15'd0, ifb.ready2}, 16'd0);
    end
    ifb.read_m1 = 1'b1; ifb.address1 = 16'h0030;
    step(); step();
    chk("t4_rd_early", {15'd0, ifb.ready1}, 16'd0);
    step();
    chk("t4_rd_ready1", {15'd0, ifb.ready1}, 16'd1);
    chk("t4_mem_kept", ifb.data1, 16'h1111);
    ifb.read_m1 = 1'b0;
    step();
`ifdef MEM_STATS_EN
    chk("stat_wr_b", ifb.wr_count, 16'd1);
    chk("stat_rd_b", ifb.rd_count, 16'd1);
`endif

    // Asynchronous reset while port 1 is BUSY
    ifa.read_m1 = 1'b1; ifa.address1 = 16'h0005;
    step();
    reset = 1'b1; #1;
    chk("t5_ready1", {15'd0, ifa.ready1}, 16'd0);
    chk("t5_data1", ifa.data1, 16'd0);
    chk("t5_data2_z", data2_a, 16'hA5A5);
    step();
    reset = 1'b0;
    rd1_a("t5_after", 16'h0005, 16'h1234);

    // Upper address bits alias onto the low index
    rd1_a("t6_alias20", 16'hFF20, 16'h5555);
    rd1_a("t6_alias05", 16'hFF05, 16'h1234);
`ifdef MEM_STATS_EN
    chk("stat_rd_post", ifa.rd_count, 16'd3);
    chk("stat_wr_post", ifa.wr_count, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the pipelined CPU's two memory ports: port 1 (instruction fetch, read-only) and port 2 (data read/write over a shared bidirectional bus).
- Each port has an independent latency FSM, so the CPU sees a configurable multi-cycle memory.
- Completion of each access is signalled by a one-cycle ready pulse.
- Sits outside the datapath in the top-level/testbench and replaces the ideal zero-latency memory.

Parameters:
- WORD_SIZE, 16, data and address width.
- ADDR_BITS, 8, index bits used; depth = 2**ADDR_BITS words.
- LATENCY, 2, cycles from request sample to response; legal range 1..15.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- read_m1  input  1  port-1 read request; held until ready1.
- address1  input  WORD_SIZE  port-1 address.
- data1  output  WORD_SIZE  port-1 read data; registered.
- ready1  output  1  port-1 completion pulse.
- read_m2  input  1  port-2 read request.
- write_m2  input  1  port-2 write request.
- address2  input  WORD_SIZE  port-2 address.
- data2  inout  WORD_SIZE  port-2 data; CPU drives on write, responder drives on read response.
- ready2  output  1  port-2 completion pulse, for reads and writes.

Behaviour:
- Storage: array of 2**ADDR_BITS words, indexed by address[ADDR_BITS-1:0]. Upper address bits are ignored (aliasing). Reset does not clear contents.
- Per-port FSM states: IDLE, BUSY, RESP. Counter width is 4 bits.
- IDLE: at a rising edge with a request high, latch the address and op. Port 2 also latches data2 if writing.
  - LATENCY=1: go directly to RESP.
  - Otherwise: go to BUSY with cnt = LATENCY-1.
- BUSY: cnt decrements each edge.
  - At the edge where cnt==1, go to RESP.
  - If the request is deasserted at any BUSY edge, abort to IDLE: no response, and no write commit.
- Entering RESP: reads sample the array into the data register; writes commit the latched data to the array.
- RESP: lasts exactly 1 cycle with ready=1. Always returns to IDLE at the next edge. Requests are not sampled in BUSY or RESP.
- Latency: request sampled at edge t0, so ready is high in the cycle after edge t0+LATENCY-1. Back-to-back throughput is 1 access per LATENCY+1 cycles per port.
- Port 2 with read_m2 and write_m2 both high: treated as a write.
- data2 is driven by the responder only in RESP of a port-2 read; it is high-Z otherwise.
- Same-address collision (port-1 read and port-2 write entering RESP on the same edge): port 1 returns the old data (read-before-write).
- Ports are fully independent; simultaneous accesses never stall each other.
- Reset (asynchronous, any state): FSMs to IDLE, cnt=0, ready1=ready2=0, data1=0, data2=Z. In-flight writes are discarded.
- data1 holds its last value outside RESP.

Optional Feature:
- Macro MEM_STATS_EN.
- Defined: adds outputs rd_count and wr_count (each WORD_SIZE bits, reset 0).
  - rd_count increments once per completed read on either port; +2 if both complete in the same cycle.
  - wr_count increments once per committed write.
  - Aborted accesses are not counted. Both counters wrap from 16'hFFFF to 0.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Preload word 0x05=16'h1234; LATENCY=2; read_m1=1, address1=16'h0005 sampled at edge 0 -> ready1=1 and data1=16'h1234 in the cycle after edge 1, ready1=0 after edge 2.
- write_m2=1, address2=16'h0010, data2=16'hBEEF held until ready2; then read_m2 at the same address -> ready2 pulse, data2 driven as 16'hBEEF only during RESP, Z otherwise.
- Port-1 read and port-2 write of 16'h5555 to address 0x20 (old value 16'hAAAA), issued on the same edge -> data1=16'hAAAA; a later read returns 16'h5555.
- write_m2 deasserted one cycle after sampling (LATENCY=3) -> no ready2 pulse; memory unchanged (MEM_STATS_EN: wr_count stays 0).
- Assert reset while port 1 is in BUSY -> ready1=0, data1=0, data2=Z immediately; after release, a new read completes normally with the full LATENCY.
- address1=16'hFF05 with ADDR_BITS=8 -> returns the contents of word 0x05 (alias check).
